// File: rtl/psum_fifo_arbiter_pkg.sv
// Shared accelerator definitions for the partial-sum FIFO front end:
// default sizes and the read-side state encoding.
package psum_fifo_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 25;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_NUM_REQ    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } rd_state_e;

endpackage

// File: rtl/psum_fifo_arbiter_rr_arbiter.sv
// Round-robin priority search: first asserted request strictly after 'last',
// wrapping around, so the most recently served requester has lowest priority.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    grant   = last;
    any_req = 1'b0;
    idx     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last) + off) % NUM_REQ);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psum_fifo_arbiter.sv
// Arbitrates NUM_REQ partial-sum writers into an external SYNCH_FIFO and
// drains it through a valid/ready read port, tracking FIFO occupancy.
module psum_fifo_arbiter
  import psum_fifo_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_data_out,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic [IDX_W-1:0]              grant_id,
  output logic [ADDR_WIDTH:0]           count
);

  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  grant;
  logic              any_req;
  logic              wr_accept;
  rd_state_e         state_q;
  logic              fifo_rd_en_q;
  logic              out_valid_q;
  logic [ADDR_WIDTH:0] count_q, count_d;

  // ---------------- write side ----------------
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req     (req_valid),
    .last    (last_grant_q),
    .grant   (grant),
    .any_req (any_req)
  );

  // Gated by rst_n so no write is accepted while the FIFO itself is held in reset.
  assign wr_accept = rst_n & any_req & ~fifo_full;
  assign fifo_wr_en = wr_accept;
  assign last_grant_d = wr_accept ? grant : last_grant_q;
  assign grant_id = any_req ? grant : last_grant_q;

  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    req_ready[grant] = wr_accept;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDX_W'(i)) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) last_grant_q <= IDX_W'(NUM_REQ - 1);
    else        last_grant_q <= last_grant_d;
  end

  // ---------------- read side ----------------
  // fifo_rd_en and out_valid are decoded one edge early so they leave flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fifo_rd_en_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q      <= FETCH;
            fifo_rd_en_q <= 1'b1;
          end
        end
        FETCH: begin
          state_q      <= VALID;
          fifo_rd_en_q <= 1'b0;
          out_valid_q  <= 1'b1;
        end
        VALID: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!fifo_empty) begin
              state_q      <= FETCH;
              fifo_rd_en_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          fifo_rd_en_q <= 1'b0;
          out_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign out_valid  = out_valid_q;
  // The FIFO output register only moves on a pop, so this stays stable while stalled.
  assign out_data   = fifo_data_out;

  // ---------------- occupancy ----------------
  always_comb begin
    count_d = count_q;
    if (fifo_wr_en && !fifo_rd_en && count_q != COUNT_MAX) count_d = count_q + 1'b1;
    else if (fifo_rd_en && !fifo_wr_en && count_q != '0)   count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_psum_fifo_arbiter.sv
// Self-checking bench: behavioural FIFO plus a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_psum_fifo_arbiter;

  localparam int DW    = 25;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int NR    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             out_ready = 1'b0;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data_in;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_data_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       grant_id;
  logic [AW:0]      count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  psum_fifo_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .grant_id      (grant_id),
    .count         (count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [NR*DW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [NR*DW-1:0] v, input int i);
    logic [NR*DW-1:0] t;
    t = v >> (i * DW);
    return t[DW-1:0];
  endfunction

  // Round-robin rule: first requester after 'last', wrapping; -1 if none.
  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- behavioural SYNCH_FIFO ----------------
  logic [DW-1:0] fq[$];
  int            fq_n = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fq_n          <= 0;
      fifo_data_out <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        fifo_data_out <= fq[0];
        void'(fq.pop_front());
      end
      if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_data_in);
      fq_n <= fq.size();
    end
  end

  assign fifo_full  = (fq_n == DEPTH);
  assign fifo_empty = (fq_n == 0);

  // ---------------- reference model + per-cycle compare ----------------
  int            m_last = NR - 1;
  int            m_occ  = 0;
  logic [DW-1:0] m_exp[$];
  logic          p_rd   = 1'b0;
  logic          p_hold = 1'b0;
  logic [DW-1:0] p_data = '0;

  always @(negedge clk) begin
    int            g;
    logic [NR-1:0] er;
    if (!rst_n) begin
      m_last = NR - 1;
      m_occ  = 0;
      m_exp.delete();
      p_rd   = 1'b0;
      p_hold = 1'b0;
    end else begin
      g  = rr_pick(req_valid, m_last);
      er = '0;
      if (g >= 0 && !fifo_full) er[g] = 1'b1;
      check("mon_req_ready", req_ready, er);
      check("mon_wr_en", fifo_wr_en, |er);
      if (g >= 0) check("mon_grant_id", grant_id, g);
      else        check("mon_grant_id_idle", grant_id, m_last);
      if (er != '0) check("mon_wr_data", fifo_data_in, word_of(req_data, g));
      check("mon_count", count, m_occ);
      check("mon_rd_when_empty", fifo_rd_en & fifo_empty, 0);
      check("mon_rd_and_valid", fifo_rd_en & out_valid, 0);
      if (p_rd) check("mon_valid_after_fetch", out_valid, 1);
      if (p_hold) begin
        check("mon_hold_valid", out_valid, 1);
        check("mon_hold_data", out_data, p_data);
        check("mon_hold_no_rd", fifo_rd_en, 0);
      end
      if (out_valid) begin
        check("mon_out_pending", m_exp.size() > 0, 1);
        if (m_exp.size() > 0) check("mon_out_data", out_data, m_exp[0]);
      end
      if (er != '0) begin
        m_last = g;
        m_occ++;
        m_exp.push_back(word_of(req_data, g));
      end
      if (fifo_rd_en) m_occ--;
      if (out_valid && out_ready && m_exp.size() > 0) void'(m_exp.pop_front());
      p_rd   = fifo_rd_en;
      p_hold = out_valid && !out_ready;
      p_data = out_data;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    out_ready = 1'b1;
    while ((count != 0 || out_valid || !fifo_empty) && n < 60) begin
      tick();
      n++;
    end
    check("drain_done", n < 60, 1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 12);
    check(name, out_valid, 1);
  endtask

  logic [DW-1:0] rr_words [4] = '{25'h11, 25'h22, 25'h33, 25'h44};
  int            ov_exp   [7] = '{0, 0, 0, 1, 0, 1, 0};
  int            cnt_exp  [7] = '{0, 1, 2, 1, 1, 0, 0};

  initial begin
    int n;

    // Reset state, with requests pending to show they are not accepted.
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_count", count, 0);
    check("rst_grant_id", grant_id, 3);
    req_valid = 4'hf;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    req_valid = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // All four requesting: writes in order 0,1,2,3,0,1 one per cycle.
    tick();
    req_data  = pack4(25'h11, 25'h22, 25'h33, 25'h44);
    req_valid = 4'hf;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_order_ready", req_ready, 4'b0001 << (i % 4));
      check("rr_order_data", fifo_data_in, rr_words[i % 4]);
      tick();
    end
    drain();

    // Only requester 2: granted every cycle, remembered once idle.
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("single_ready", req_ready, 4'b0100);
      check("single_grant", grant_id, 2);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    check("single_last_grant", grant_id, 2);
    tick();
    drain();

    // Fill with requesters 1 and 2 alternating, consumer stalled.
    out_ready = 1'b0;
    req_data  = pack4(25'h0, 25'h101, 25'h202, 25'h0);
    req_valid = 4'b0110;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_full && n < 30);
    check("full_reached", fifo_full, 1);
    for (int i = 0; i < 3; i++) begin
      check("full_req_ready", req_ready, 0);
      check("full_wr_en", fifo_wr_en, 0);
      check("full_grant_frozen", grant_id, 2);
      check("full_count", count, DEPTH);
      tick();
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_wr_en && n < 6);
    check("resume_seen", fifo_wr_en, 1);
    check("resume_requester", req_ready, 4'b0100);
    tick();
    drain();

    // Push 1 then 2 with the consumer always ready.
    req_data  = pack4(25'd1, 25'd0, 25'd0, 25'd0);
    req_valid = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) req_data = pack4(25'd2, 25'd0, 25'd0, 25'd0);
      if (i == 2) req_valid = '0;
      @(negedge clk);
      check("pulse_valid", out_valid, ov_exp[i]);
      check("pulse_count", count, cnt_exp[i]);
      if (i == 3) check("pulse_data_first", out_data, 1);
      if (i == 5) check("pulse_data_second", out_data, 2);
      tick();
    end
    drain();

    // Stall for five cycles in VALID.
    out_ready = 1'b0;
    req_data  = pack4(25'h0, 25'h0, 25'h0, 25'h5A5);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_valid("stall_valid_seen");
    for (int i = 0; i < 5; i++) begin
      check("stall_data", out_data, 25'h5A5);
      check("stall_no_rd", fifo_rd_en, 0);
      check("stall_count", count, 0);
      tick();
      @(negedge clk);
    end
    tick();
    drain();

    // Reset pulsed during FETCH with three words buffered.
    out_ready = 1'b0;
    req_data  = pack4(25'h0B1, 25'h0A1, 25'h0, 25'h0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_valid("abort_first_valid");
    tick();
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("abort_pre_rd_en", fifo_rd_en, 1);
    check("abort_pre_count", count, 3);
    #1 rst_n = 1'b0;
    req_valid = 4'hf;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_rd_en", fifo_rd_en, 0);
    check("abort_wr_en", fifo_wr_en, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_count", count, 0);
    req_valid = '0;
    #1;
    check("abort_grant_id", grant_id, 3);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Normal operation resumes after the abort.
    tick();
    req_data  = pack4(25'h1234, 25'h0, 25'h0, 25'h0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("post_reset_ready", req_ready, 4'b0001);
    tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/psum_fifo_arbiter.md
PSUM_FIFO_ARBITER -- requirements
Module: psum_fifo_arbiter

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL have parameter DATA_WIDTH, 25, width of one partial-sum word.
REQ-002 SHALL have parameter ADDR_WIDTH, 3, address width of the attached SYNCH_FIFO.
REQ-003 SHALL have parameter DEPTH, 8, number of entries in the attached SYNCH_FIFO.
REQ-004 SHALL have parameter NUM_REQ, 4, number of write requesters.

Ports, one per line: name, direction, width, meaning.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester write request.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready, output, NUM_REQ, one-hot write accept.
REQ-010 SHALL have port out_valid, output, 1, read data available.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, read data.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-013 SHALL have ports fifo_wr_en (output, 1), fifo_data_in (output, DATA_WIDTH), fifo_rd_en (output, 1), fifo_data_out (input, DATA_WIDTH), fifo_full (input, 1) and fifo_empty (input, 1), connected to SYNCH_FIFO.
REQ-014 SHALL have port grant_id, output, $clog2(NUM_REQ), index of the requester currently granted.
REQ-015 SHALL have port count, output, ADDR_WIDTH+1, tracked FIFO occupancy.

Function
REQ-016 Write arbitration SHALL be round-robin: the grant goes to the first asserted req_valid, searching upward with wrap-around from index last_grant+1.
REQ-017 req_ready[g] SHALL be 1 only when requester g is granted, req_valid[g]=1 and fifo_full=0; all other req_ready bits SHALL be 0.
REQ-018 fifo_wr_en SHALL equal the OR of req_ready, and fifo_data_in SHALL be req_data slice g; the path is combinational with zero latency.
REQ-019 last_grant SHALL update to g only on a cycle with an accepted write; it SHALL hold otherwise, including when fifo_full blocks the write.
REQ-020 grant_id SHALL show g while any req_valid is set, and last_grant otherwise.
REQ-021 The read FSM SHALL have states IDLE, FETCH and VALID, with these transitions:
- IDLE to FETCH when fifo_empty=0.
- FETCH to VALID unconditionally.
- VALID to FETCH when out_ready=1 and fifo_empty=0.
- VALID to IDLE when out_ready=1 and fifo_empty=1.
- VALID holds when out_ready=0.
REQ-022 fifo_rd_en SHALL be 1 exactly in FETCH; the FIFO presents data on the edge that leaves FETCH.
REQ-023 out_valid SHALL be 1 exactly in VALID, and out_data SHALL pass fifo_data_out through unchanged while in VALID; out_data is don't-care in other states.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Read throughput SHALL be at most one word per 2 cycles; write throughput SHALL be one word per cycle.
REQ-026 count SHALL:
- increment by 1 on fifo_wr_en alone;
- decrement by 1 on fifo_rd_en alone;
- stay unchanged when both or neither are asserted.
REQ-027 fifo_wr_en SHALL never be asserted while fifo_full=1, and fifo_rd_en SHALL never be asserted while fifo_empty=1.
REQ-028 A write and a read in the same cycle SHALL both occur; a write into an empty FIFO SHALL make the read FSM leave IDLE on the following cycle.

Reset
REQ-029 While rst_n=0 the block SHALL hold: FSM=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), count=0, out_valid=0, fifo_rd_en=0, fifo_wr_en=0, req_ready=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately, and SHALL be applied together with the FIFO's own reset.

Structure
REQ-031 DATA_WIDTH, ADDR_WIDTH, DEPTH and NUM_REQ defaults and the read-FSM state encoding SHALL live in the shared accelerator package.
REQ-032 The round-robin priority search SHALL be a sub-module rr_arbiter with inputs req and last and outputs grant index and any_req.
REQ-033 The SYNCH_FIFO SHALL be instantiated outside this block, one level up.

Verification
REQ-034 After reset, with all four req_valid held at 1 and data 0x11, 0x22, 0x33, 0x44, the FIFO SHALL receive writes in order 0,1,2,3,0,1,... one per cycle.
REQ-035 With only req_valid[2]=1, it SHALL be granted every cycle and last_grant SHALL be 2.
REQ-036 With writes continuing after 8 writes, the ninth write SHALL have fifo_full=1, req_ready=0 and last_grant frozen; after one read it SHALL proceed with the same requester.
REQ-037 With push 1 then 2 and out_ready=1, out_valid SHALL pulse with 1, then 2, two cycles apart, and count SHALL go 1, 2, 1, 0.
REQ-038 With out_ready=0 for 5 cycles in VALID, out_data SHALL stay constant, no fifo_rd_en SHALL be issued and count SHALL be unchanged.
REQ-039 With rst_n pulsed low during FETCH at count=3, all outputs SHALL be at reset values within the same cycle, and count SHALL read 0.
